// File: rtl/spk_sched.sv
// rtl/spk_sched.sv - two-port packet scheduler feeding the axon sliding-window engine
//
// Purpose: arbitrates between a router-side port (ext) and a local loopback
// port (loc), each buffered by its own FIFO of 2^DEPTH_LOG {type,data} entries,
// and issues one packet at a time to the axon engine. DATA bursts lock the
// grant until DATA_END; every completed grant is followed by a one-cycle HOLD
// so the axon busy flag reflects the last issue before the next decision.
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   ext_vld/ext_rdy/ext_data/ext_type router-side push port
//   loc_vld/loc_rdy/loc_data/loc_type loopback push port
//   axon_busy                         axon engine busy (combinational from axon)
//   spk_in_axon_vld/_data/_type       registered one-cycle issue to axon
//   sched_idle                        FIFOs empty, no lock, nothing pending
//   spk_cnt, stall_cnt                statistics, only with SPK_SCHED_STAT_EN
//
// Optional feature macro: SPK_SCHED_STAT_EN

module spk_sched_fifo #(
  parameter int W  = 27,
  parameter int DL = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         empty,
  output logic         full
);
  localparam int DEPTH = 1 << DL;

  logic [W-1:0]  mem [DEPTH];
  logic [DL-1:0] wptr;
  logic [DL-1:0] rptr;
  logic [DL:0]   count;

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + DL'(1);
      if (pop)  rptr <= rptr + DL'(1);
      case ({push, pop})
        2'b10:   count <= count + (DL+1)'(1);
        2'b01:   count <= count - (DL+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rptr];
  assign empty = (count == '0);
  assign full  = (count == (DL+1)'(DEPTH));
endmodule

module spk_sched #(
  parameter int SW        = 24,
  parameter int FTW       = 3,
  parameter int DEPTH_LOG = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ext_vld,
  output logic           ext_rdy,
  input  logic [SW-1:0]  ext_data,
  input  logic [FTW-1:0] ext_type,
  input  logic           loc_vld,
  output logic           loc_rdy,
  input  logic [SW-1:0]  loc_data,
  input  logic [FTW-1:0] loc_type,
  input  logic           axon_busy,
  output logic           spk_in_axon_vld,
  output logic [SW-1:0]  spk_in_axon_data,
  output logic [FTW-1:0] spk_in_axon_type,
  output logic           sched_idle
`ifdef SPK_SCHED_STAT_EN
  ,
  output logic [15:0]    spk_cnt,
  output logic [15:0]    stall_cnt
`endif
);
  localparam int PW = SW + FTW;
  localparam logic [FTW-1:0] T_SPIKE    = FTW'(0);
  localparam logic [FTW-1:0] T_DATA     = FTW'(1);
  localparam logic [FTW-1:0] T_DATA_END = FTW'(2);

  typedef enum logic [1:0] {ARB, LOCK, HOLD} state_t;

  state_t state, state_nxt;
  logic   lock_loc, lock_nxt;   // port owning the current burst (1 = loc)
  logic   last_loc, last_nxt;   // port of the last completed grant (1 = loc)

  logic          ext_full, ext_empty, loc_full, loc_empty;
  logic          ext_push, loc_push, ext_pop, loc_pop;
  logic [PW-1:0] ext_head, loc_head, head;
  logic [FTW-1:0] head_type;
  logic          issue, sel_loc;

  // Ready is forced high during reset so upstream sees a clean, open port.
  assign ext_rdy  = rst | ~ext_full;
  assign loc_rdy  = rst | ~loc_full;
  assign ext_push = ext_vld & ext_rdy;
  assign loc_push = loc_vld & loc_rdy;

  spk_sched_fifo #(.W(PW), .DL(DEPTH_LOG)) u_ext_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (ext_push),
    .wdata ({ext_type, ext_data}),
    .pop   (ext_pop),
    .rdata (ext_head),
    .empty (ext_empty),
    .full  (ext_full)
  );

  spk_sched_fifo #(.W(PW), .DL(DEPTH_LOG)) u_loc_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (loc_push),
    .wdata ({loc_type, loc_data}),
    .pop   (loc_pop),
    .rdata (loc_head),
    .empty (loc_empty),
    .full  (loc_full)
  );

  assign head      = sel_loc ? loc_head : ext_head;
  assign head_type = head[PW-1:SW];
  assign ext_pop   = issue & ~sel_loc;
  assign loc_pop   = issue & sel_loc;

  always_comb begin
    state_nxt = state;
    lock_nxt  = lock_loc;
    last_nxt  = last_loc;
    issue     = 1'b0;
    sel_loc   = 1'b0;
    case (state)
      ARB: begin
        if (!axon_busy && (!ext_empty || !loc_empty)) begin
          issue = 1'b1;
          // With both heads present, go opposite to the last completed grant.
          sel_loc = !loc_empty && (ext_empty || !last_loc);
          if (head_type == T_DATA) begin
            state_nxt = LOCK;
            lock_nxt  = sel_loc;
          end else begin
            state_nxt = HOLD;
            last_nxt  = sel_loc;
          end
        end
      end
      LOCK: begin
        // Axon busy is ignored inside a burst; an empty FIFO just stalls.
        sel_loc = lock_loc;
        issue   = lock_loc ? !loc_empty : !ext_empty;
        if (issue && head_type == T_DATA_END) begin
          state_nxt = HOLD;
          last_nxt  = lock_loc;
        end
      end
      HOLD: begin
        state_nxt = ARB;
      end
      default: begin
        state_nxt = ARB;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= ARB;
      lock_loc         <= 1'b0;
      last_loc         <= 1'b1;  // ext wins the first tie after reset
      spk_in_axon_vld  <= 1'b0;
      spk_in_axon_data <= '0;
      spk_in_axon_type <= '0;
    end else begin
      state           <= state_nxt;
      lock_loc        <= lock_nxt;
      last_loc        <= last_nxt;
      spk_in_axon_vld <= issue;
      if (issue) begin
        spk_in_axon_data <= head[SW-1:0];
        spk_in_axon_type <= head_type;
      end
    end
  end

  assign sched_idle = rst | (ext_empty & loc_empty & (state == ARB) & ~spk_in_axon_vld);

`ifdef SPK_SCHED_STAT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      spk_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      if (issue && head_type == T_SPIKE && spk_cnt != 16'hFFFF) begin
        spk_cnt <= spk_cnt + 16'd1;
      end
      if (state == ARB && (!ext_empty || !loc_empty) && axon_busy && stall_cnt != 16'hFFFF) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end
`endif
endmodule

// File: tb/tb_spk_sched.sv
// tb/tb_spk_sched.sv - scoreboard bench for spk_sched against a queue-based reference model
module tb_spk_sched;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ext_vld = 1'b0, loc_vld = 1'b0, axon_busy = 1'b0;
  logic [23:0] ext_data = '0, loc_data = '0;
  logic [2:0]  ext_type = '0, loc_type = '0;
  logic        ext_rdy, loc_rdy, spk_in_axon_vld, sched_idle;
  logic [23:0] spk_in_axon_data;
  logic [2:0]  spk_in_axon_type;
`ifdef SPK_SCHED_STAT_EN
  logic [15:0] spk_cnt, stall_cnt;
`endif

  spk_sched dut (
    .clk              (clk),
    .rst              (rst),
    .ext_vld          (ext_vld),
    .ext_rdy          (ext_rdy),
    .ext_data         (ext_data),
    .ext_type         (ext_type),
    .loc_vld          (loc_vld),
    .loc_rdy          (loc_rdy),
    .loc_data         (loc_data),
    .loc_type         (loc_type),
    .axon_busy        (axon_busy),
    .spk_in_axon_vld  (spk_in_axon_vld),
    .spk_in_axon_data (spk_in_axon_data),
    .spk_in_axon_type (spk_in_axon_type),
    .sched_idle       (sched_idle)
`ifdef SPK_SCHED_STAT_EN
    ,
    .spk_cnt          (spk_cnt),
    .stall_cnt        (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {logic [2:0] t; logic [23:0] d;} pkt_t;
  typedef struct {logic [2:0] t; logic [23:0] d; int c;} exp_t;

  pkt_t src_e[$], src_l[$];   // packets waiting to be offered on each port
  pkt_t mq_e[$], mq_l[$];     // model FIFO contents
  exp_t exp_q[$];             // scoreboard of expected issues
  int   cyc = 0, checks = 0, errors = 0;
  int   m_lock = -1, m_last = 1, m_spk = 0, m_stall = 0;
  bit   m_hold = 0;
  bit   gate_e = 1, gate_l = 1, acc_e = 0, acc_l = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: one step per rising edge, from the scheduling rules.
  always @(posedge clk) begin
    pkt_t p;
    int   port;
    bit   any_e, any_l;
    cyc++;
    acc_e = ext_vld && (rst || mq_e.size() < 4);
    acc_l = loc_vld && (rst || mq_l.size() < 4);
    if (rst) begin
      mq_e.delete(); mq_l.delete(); exp_q.delete();
      m_lock = -1; m_last = 1; m_hold = 0; m_spk = 0; m_stall = 0;
    end else begin
      any_e = mq_e.size() > 0;
      any_l = mq_l.size() > 0;
      port  = -1;
      if (m_hold) m_hold = 0;
      else if (m_lock >= 0) begin
        if (m_lock == 0 ? any_e : any_l) port = m_lock;
      end else if (axon_busy) begin
        if ((any_e || any_l) && m_stall < 65535) m_stall++;
      end else if (any_e && any_l) port = 1 - m_last;
      else if (any_e) port = 0;
      else if (any_l) port = 1;
      if (port >= 0) begin
        if (port == 0) p = mq_e.pop_front();
        else           p = mq_l.pop_front();
        exp_q.push_back('{p.t, p.d, cyc});
        if (p.t == 3'd0 && m_spk < 65535) m_spk++;
        if (m_lock >= 0) begin
          if (p.t == 3'd2) begin m_last = m_lock; m_lock = -1; m_hold = 1; end
        end else if (p.t == 3'd1) m_lock = port;
        else begin m_last = port; m_hold = 1; end
      end
      if (acc_e) mq_e.push_back('{ext_type, ext_data});
      if (acc_l) mq_l.push_back('{loc_type, loc_data});
    end
  end

  // Port drivers: hold a packet until the model says it was accepted.
  always @(posedge clk) begin
    #1;
    if (acc_e && src_e.size() > 0) src_e.delete(0);
    if (acc_l && src_l.size() > 0) src_l.delete(0);
    ext_vld = gate_e && src_e.size() > 0;
    loc_vld = gate_l && src_l.size() > 0;
    if (src_e.size() > 0) begin ext_data = src_e[0].d; ext_type = src_e[0].t; end
    if (src_l.size() > 0) begin loc_data = src_l[0].d; loc_type = src_l[0].t; end
  end

  // Monitor: compare every DUT issue and status output against the model.
  always @(negedge clk) begin
    exp_t e;
    if (spk_in_axon_vld) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL issue: unexpected issue data %h type %h at cycle %0d, required none",
                 spk_in_axon_data, spk_in_axon_type, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("issue_cycle", 32'(cyc), 32'(e.c));
        chk("issue_data", {8'h0, spk_in_axon_data}, {8'h0, e.d});
        chk("issue_type", {29'h0, spk_in_axon_type}, {29'h0, e.t});
      end
    end
    if (exp_q.size() > 0 && exp_q[0].c <= cyc) begin
      e = exp_q.pop_front();
      checks++; errors++;
      $display("FAIL missed_issue: no issue at cycle %0d, required data %h type %h", cyc, e.d, e.t);
    end
    chk("ext_rdy", {31'h0, ext_rdy}, {31'h0, rst || mq_e.size() < 4});
    chk("loc_rdy", {31'h0, loc_rdy}, {31'h0, rst || mq_l.size() < 4});
    chk("sched_idle", {31'h0, sched_idle},
        {31'h0, rst || (mq_e.size() == 0 && mq_l.size() == 0 && m_lock < 0 && !m_hold)});
`ifdef SPK_SCHED_STAT_EN
    chk("spk_cnt", {16'h0, spk_cnt}, 32'(m_spk));
    chk("stall_cnt", {16'h0, stall_cnt}, 32'(m_stall));
`endif
  end

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic add_group(input bit to_loc);
    int   r, n;
    pkt_t p;
    r = $urandom_range(0, 9);
    if (r < 5) begin
      p = '{3'd0, 24'($urandom)};
      if (to_loc) src_l.push_back(p); else src_e.push_back(p);
    end else if (r < 7) begin
      p = '{3'($urandom_range(2, 7)), 24'($urandom)};
      if (to_loc) src_l.push_back(p); else src_e.push_back(p);
    end else begin
      n = $urandom_range(1, 3);
      for (int i = 0; i <= n; i++) begin
        p = '{(i == n) ? 3'd2 : 3'd1, 24'($urandom)};
        if (to_loc) src_l.push_back(p); else src_e.push_back(p);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset state
    step(3);
    chk("rst_vld", {31'h0, spk_in_axon_vld}, 32'h0);
    chk("rst_data", {8'h0, spk_in_axon_data}, 32'h0);
    chk("rst_type", {29'h0, spk_in_axon_type}, 32'h0);
    rst = 1'b0;
    step(1);
    chk("post_rst_idle", {31'h0, sched_idle}, 32'h1);

    // Single ext SPIKE: accepted on the next edge, issued one edge later
    src_e.push_back('{3'd0, 24'h010203});
    n = 0;
    while (!spk_in_axon_vld && n < 10) begin step(1); n++; end
    chk("p1_latency_steps", 32'(n), 32'd3);
    chk("p1_data", {8'h0, spk_in_axon_data}, 32'h010203);
    step(2);
    chk("p1_idle", {31'h0, sched_idle}, 32'h1);

    // Both ports stream SPIKEs with axon free: round-robin with HOLD gaps
    for (int i = 0; i < 8; i++) begin
      src_e.push_back('{3'd0, 24'h100000 + 24'(i)});
      src_l.push_back('{3'd0, 24'h800000 + 24'(i)});
    end
    step(40);

    // axon busy for 10 cycles with a queued SPIKE
    axon_busy = 1'b1;
    step(2);
    src_e.push_back('{3'd0, 24'h0000aa});
    step(10);
    axon_busy = 1'b0;
    step(6);

    // loc DATA burst while ext holds SPIKEs
    for (int i = 0; i < 3; i++) src_e.push_back('{3'd0, 24'h200000 + 24'(i)});
    src_l.push_back('{3'd1, 24'h300001});
    src_l.push_back('{3'd1, 24'h300002});
    src_l.push_back('{3'd2, 24'h300003});
    step(30);

    // Fill the ext FIFO while axon is busy
    axon_busy = 1'b1;
    for (int i = 0; i < 6; i++) src_e.push_back('{3'd0, 24'h400000 + 24'(i)});
    step(10);
    chk("full_ext_rdy", {31'h0, ext_rdy}, 32'h0);
    axon_busy = 1'b0;
    step(30);

    // Reset in the middle of a burst
    for (int i = 0; i < 3; i++) src_l.push_back('{3'd1, 24'h500000 + 24'(i)});
    src_l.push_back('{3'd2, 24'h5000ff});
    n = 0;
    while (!spk_in_axon_vld && n < 40) begin step(1); n++; end
    chk("p6_first_data_seen", {31'h0, spk_in_axon_vld}, 32'h1);
    rst = 1'b1;
    src_e.delete(); src_l.delete();
    step(1);
    rst = 1'b0;
    step(1);
    chk("p6_idle_after_rst", {31'h0, sched_idle}, 32'h1);
    step(10);

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      if (src_e.size() == 0) add_group(1'b0);
      if (src_l.size() == 0) add_group(1'b1);
      gate_e    = ($urandom_range(0, 9) < 7);
      gate_l    = ($urandom_range(0, 9) < 7);
      axon_busy = ($urandom_range(0, 3) == 0);
      step(1);
    end

    // Drain
    gate_e = 1; gate_l = 1; axon_busy = 1'b0;
    n = 0;
    while ((src_e.size() > 0 || src_l.size() > 0 || !sched_idle) && n < 300) begin step(1); n++; end
    step(3);
    chk("drain_idle", {31'h0, sched_idle}, 32'h1);
    chk("drain_pending", 32'(exp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
